// File: rtl/prog_uart_pkg.sv
// prog_uart_pkg: shared state encodings for the UART programming receiver
package prog_uart_pkg;
   typedef enum logic [1:0] {ST_PREAMBLE, ST_LEN, ST_DATA} top_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   localparam top_state_t DEFAULT_STATE = ST_PREAMBLE;
endpackage

// File: rtl/prog_uart_rx_bayt.sv
// prog_uart_rx_bayt: line synchroniser and 8N1 byte receiver
module prog_uart_rx_bayt
   import prog_uart_pkg::*;
#(
   parameter int BAUD_DIV = 868
)(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);
   localparam int CW = $clog2(BAUD_DIV);
   localparam logic [CW-1:0] FULL = CW'(BAUD_DIV - 1);
   localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2 - 1);

   logic [1:0]    r_sync;
   logic          r_prev;
   rx_state_t     r_state, w_state_nx;
   logic [CW-1:0] r_cnt, w_cnt_nx;
   logic [2:0]    r_bit, w_bit_nx;
   logic [7:0]    r_shift, w_shift_nx;
   logic          r_valid, w_valid_nx;
   logic          r_ferr, w_ferr_nx;
   logic          w_rx;

   assign w_rx         = r_sync[1];
   assign byte_o       = r_shift;
   assign byte_valid_o = r_valid;
   assign frame_err_o  = r_ferr;

   // synchroniser and receiver state registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync  <= 2'b11;
         r_prev  <= 1'b1;
         r_state <= RX_IDLE;
         r_cnt   <= '0;
         r_bit   <= '0;
         r_shift <= '0;
         r_valid <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], rx_i};
         r_prev  <= w_rx;
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bit   <= w_bit_nx;
         r_shift <= w_shift_nx;
         r_valid <= w_valid_nx;
         r_ferr  <= w_ferr_nx;
      end
   end

   // bit timing: half-bit start check, then one sample per bit period
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt + 1'b1;
      w_bit_nx   = r_bit;
      w_shift_nx = r_shift;
      w_valid_nx = 1'b0;
      w_ferr_nx  = 1'b0;
      case (r_state)
         RX_IDLE: begin
            w_cnt_nx = '0;
            w_bit_nx = '0;
            if (r_prev && !w_rx) w_state_nx = RX_START;
         end
         RX_START: if (r_cnt == HALF) begin
            w_cnt_nx   = '0;
            w_state_nx = w_rx ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (r_cnt == FULL) begin
            w_cnt_nx   = '0;
            w_shift_nx = {w_rx, r_shift[7:1]};
            w_bit_nx   = r_bit + 1'b1;
            if (r_bit == 3'd7) w_state_nx = RX_STOP;
         end
         default: if (r_cnt == FULL) begin
            w_cnt_nx   = '0;
            w_state_nx = RX_IDLE;
            w_valid_nx = w_rx;
            w_ferr_nx  = !w_rx;
         end
      endcase
   end
endmodule

// File: rtl/prog_uart_alici.sv
// prog_uart_alici: UART programming endpoint; optional idle-gap abort via PROG_TIMEOUT_EN
module prog_uart_alici
   import prog_uart_pkg::*;
#(
   parameter int                BAUD_DIV    = 868,
   parameter int                ADDR_W      = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h4000_0000,
   parameter logic [31:0]       PREAMBLE    = 32'h4C5A_494B,
   parameter logic [31:0]       TIMEOUT_CYC = 32'd10_000_000
)(
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              program_rx_i,
   output logic              prog_mode_o,
   output logic              prog_we_o,
   output logic [ADDR_W-1:0] prog_addr_o,
   output logic [31:0]       prog_data_o,
   output logic              prog_done_o,
   output logic              prog_err_o
);
   logic [7:0]        w_byte;
   logic              w_valid, w_ferr, w_abort, w_tmo;
   logic [31:0]       w_shifted;
   top_state_t        r_state, w_state_nx;
   logic [1:0]        r_idx, w_idx_nx;
   logic [1:0]        r_bcnt, w_bcnt_nx;
   logic [31:0]       r_len, w_len_nx;
   logic [31:0]       r_word, w_word_nx;
   logic [31:0]       r_index, w_index_nx;
   logic              r_fin, w_fin_nx;
   logic              r_mode, w_mode_nx;
   logic              r_we, w_we_nx;
   logic [ADDR_W-1:0] r_addr, w_addr_nx;
   logic [31:0]       r_data, w_data_nx;
   logic              r_done, w_done_nx;
   logic              r_err, w_err_nx;

   prog_uart_rx_bayt #(.BAUD_DIV(BAUD_DIV)) u_rx (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_i         (program_rx_i),
      .byte_o       (w_byte),
      .byte_valid_o (w_valid),
      .frame_err_o  (w_ferr)
   );

`ifdef PROG_TIMEOUT_EN
   logic [31:0] r_gap;
   // idle-gap counter, only running while a transfer is open
   always_ff @(posedge clk_i) begin
      if (rst_i || r_state == ST_PREAMBLE || w_valid) r_gap <= '0;
      else r_gap <= r_gap + 1'b1;
   end
   assign w_tmo = (r_gap == TIMEOUT_CYC - 1);
`else
   logic w_unused_tmo;
   assign w_unused_tmo = ^TIMEOUT_CYC;
   assign w_tmo        = 1'b0;
`endif

   assign w_abort     = w_ferr || w_tmo;
   assign w_shifted   = {w_byte, r_word[31:8]};
   assign prog_mode_o = r_mode;
   assign prog_we_o   = r_we;
   assign prog_addr_o = r_addr;
   assign prog_data_o = r_data;
   assign prog_done_o = r_done;
   assign prog_err_o  = r_err;

   // protocol state and output registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= DEFAULT_STATE;
         r_idx   <= '0;
         r_bcnt  <= '0;
         r_len   <= '0;
         r_word  <= '0;
         r_index <= '0;
         r_fin   <= 1'b0;
         r_mode  <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_data  <= '0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nx;
         r_idx   <= w_idx_nx;
         r_bcnt  <= w_bcnt_nx;
         r_len   <= w_len_nx;
         r_word  <= w_word_nx;
         r_index <= w_index_nx;
         r_fin   <= w_fin_nx;
         r_mode  <= w_mode_nx;
         r_we    <= w_we_nx;
         r_addr  <= w_addr_nx;
         r_data  <= w_data_nx;
         r_done  <= w_done_nx;
         r_err   <= w_err_nx;
      end
   end

   // preamble hunt, length capture and word assembly; bytes arrive LSB first
   always_comb begin
      w_state_nx = r_state;
      w_idx_nx   = r_idx;
      w_bcnt_nx  = r_bcnt;
      w_len_nx   = r_len;
      w_word_nx  = r_word;
      w_index_nx = r_index;
      w_fin_nx   = r_fin;
      w_mode_nx  = r_mode;
      w_we_nx    = 1'b0;
      w_addr_nx  = r_addr;
      w_data_nx  = r_data;
      w_done_nx  = 1'b0;
      w_err_nx   = r_err;
      if (r_state != ST_PREAMBLE && w_abort) begin
         w_state_nx = ST_PREAMBLE;
         w_mode_nx  = 1'b0;
         w_err_nx   = 1'b1;
         w_fin_nx   = 1'b0;
         w_idx_nx   = '0;
         w_bcnt_nx  = '0;
      end else begin
         case (r_state)
            ST_PREAMBLE: begin
               if (w_ferr) w_idx_nx = '0;
               else if (w_valid) begin
                  if (w_byte == PREAMBLE[8*r_idx +: 8]) begin
                     w_idx_nx = r_idx + 1'b1;
                     if (r_idx == 2'd3) begin
                        w_state_nx = ST_LEN;
                        w_mode_nx  = 1'b1;
                        w_err_nx   = 1'b0;
                        w_bcnt_nx  = '0;
                     end
                  end else w_idx_nx = (w_byte == PREAMBLE[7:0]) ? 2'd1 : 2'd0;
               end
            end
            ST_LEN: if (w_valid) begin
               w_word_nx = w_shifted;
               w_bcnt_nx = r_bcnt + 1'b1;
               if (r_bcnt == 2'd3) begin
                  w_len_nx   = w_shifted;
                  w_index_nx = '0;
                  w_state_nx = (w_shifted == '0) ? ST_PREAMBLE : ST_DATA;
                  w_done_nx  = (w_shifted == '0);
                  w_mode_nx  = (w_shifted != '0);
               end
            end
            default: begin
               if (r_fin) begin
                  w_fin_nx   = 1'b0;
                  w_done_nx  = 1'b1;
                  w_mode_nx  = 1'b0;
                  w_state_nx = ST_PREAMBLE;
               end else if (w_valid) begin
                  w_word_nx = w_shifted;
                  w_bcnt_nx = r_bcnt + 1'b1;
                  if (r_bcnt == 2'd3) begin
                     w_we_nx    = 1'b1;
                     w_data_nx  = w_shifted;
                     w_addr_nx  = BASE_ADDR + ADDR_W'({r_index, 2'b00});
                     w_index_nx = r_index + 1'b1;
                     w_fin_nx   = (r_index + 1'b1 == r_len);
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_prog_uart_alici.sv
// tb_prog_uart_alici: directed bench for the UART programming endpoint
module tb_prog_uart_alici;
   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        program_rx_i = 1'b1;
   logic        prog_mode_o, prog_we_o, prog_done_o, prog_err_o;
   logic [31:0] prog_addr_o, prog_data_o;
   int          checks = 0;
   int          errors = 0;
   int          n_we = 0;
   int          n_done = 0;
   logic [31:0] wa [0:15];
   logic [31:0] wd [0:15];

   prog_uart_alici #(.BAUD_DIV(16)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .program_rx_i (program_rx_i),
      .prog_mode_o  (prog_mode_o),
      .prog_we_o    (prog_we_o),
      .prog_addr_o  (prog_addr_o),
      .prog_data_o  (prog_data_o),
      .prog_done_o  (prog_done_o),
      .prog_err_o   (prog_err_o)
   );

   always #5 clk_i = ~clk_i;

   // write and done log, sampled mid-cycle
   always @(negedge clk_i) begin
      if (prog_we_o) begin
         wa[n_we[3:0]] = prog_addr_o;
         wd[n_we[3:0]] = prog_data_o;
         n_we++;
      end
      if (prog_done_o) n_done++;
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk_i);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      program_rx_i = 1'b0;
      idle(16);
      for (int i = 0; i < 8; i++) begin
         program_rx_i = b[i];
         idle(16);
      end
      program_rx_i = stop;
      idle(16);
      program_rx_i = 1'b1;
      idle(16);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 1'b1);
   endtask

   task automatic send_pre();
      send_byte(8'h4B, 1'b1);
      send_byte(8'h49, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h4C, 1'b1);
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      idle(4);
      checks++;
      if ({prog_mode_o, prog_we_o, prog_done_o, prog_err_o, prog_addr_o, prog_data_o} !== 68'h0) begin
         errors++;
         $display("FAIL reset_outputs got mode%b we%b done%b err%b addr%h data%h exp all 0",
                  prog_mode_o, prog_we_o, prog_done_o, prog_err_o, prog_addr_o, prog_data_o);
      end
      rst_i = 1'b0;
      idle(4);
   endtask

   task automatic test_basic();
      int we0 = n_we, d0 = n_done;
      send_pre();
      checks++;
      if (prog_mode_o !== 1'b1) begin errors++; $display("FAIL basic_mode_rise got %b exp 1", prog_mode_o); end
      send_word(32'd2);
      send_word(32'hDEAD_BEEF);
      checks++;
      if (n_we - we0 !== 1) begin errors++; $display("FAIL basic_first_write got %0d exp 1", n_we - we0); end
      checks++;
      if (wa[we0[3:0]] !== 32'h4000_0000 || wd[we0[3:0]] !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL basic_w0 got %h/%h exp 40000000/deadbeef", wa[we0[3:0]], wd[we0[3:0]]);
      end
      send_word(32'h0000_0013);
      checks++;
      if (n_we - we0 !== 2) begin errors++; $display("FAIL basic_write_count got %0d exp 2", n_we - we0); end
      checks++;
      if (wa[4'(we0 + 1)] !== 32'h4000_0004 || wd[4'(we0 + 1)] !== 32'h0000_0013) begin
         errors++; $display("FAIL basic_w1 got %h/%h exp 40000004/00000013", wa[4'(we0 + 1)], wd[4'(we0 + 1)]);
      end
      checks++;
      if (n_done - d0 !== 1) begin errors++; $display("FAIL basic_done got %0d exp 1", n_done - d0); end
      checks++;
      if (prog_mode_o !== 1'b0 || prog_err_o !== 1'b0) begin
         errors++; $display("FAIL basic_end got mode%b err%b exp mode0 err0", prog_mode_o, prog_err_o);
      end
      checks++;
      if (prog_addr_o !== 32'h4000_0004 || prog_data_o !== 32'h0000_0013) begin
         errors++; $display("FAIL basic_hold got %h/%h exp 40000004/00000013", prog_addr_o, prog_data_o);
      end
   endtask

   task automatic test_resync();
      int we0 = n_we, d0 = n_done;
      send_byte(8'h4B, 1'b1);
      send_pre();
      checks++;
      if (prog_mode_o !== 1'b1) begin errors++; $display("FAIL resync_mode got %b exp 1", prog_mode_o); end
      send_word(32'd0);
      checks++;
      if (n_done - d0 !== 1 || n_we !== we0) begin
         errors++; $display("FAIL resync_zero_len got done%0d we%0d exp done1 we0", n_done - d0, n_we - we0);
      end
      checks++;
      if (prog_mode_o !== 1'b0) begin errors++; $display("FAIL resync_mode_fall got %b exp 0", prog_mode_o); end
   endtask

   task automatic test_frame_err();
      int we0 = n_we, d0 = n_done;
      send_pre();
      send_word(32'd3);
      send_word(32'hA5A5_0001);
      send_byte(8'h77, 1'b0);
      checks++;
      if (n_we - we0 !== 1 || wd[we0[3:0]] !== 32'hA5A5_0001) begin
         errors++; $display("FAIL ferr_writes got %0d/%h exp 1/a5a50001", n_we - we0, wd[we0[3:0]]);
      end
      checks++;
      if (prog_err_o !== 1'b1 || prog_mode_o !== 1'b0 || n_done !== d0) begin
         errors++; $display("FAIL ferr_abort got err%b mode%b done%0d exp err1 mode0 done0",
                            prog_err_o, prog_mode_o, n_done - d0);
      end
      send_pre();
      checks++;
      if (prog_err_o !== 1'b0 || prog_mode_o !== 1'b1) begin
         errors++; $display("FAIL ferr_clear got err%b mode%b exp err0 mode1", prog_err_o, prog_mode_o);
      end
      send_word(32'd0);
   endtask

   task automatic test_glitch();
      int we0 = n_we, d0 = n_done;
      send_byte(8'h4B, 1'b1);
      program_rx_i = 1'b0;
      idle(5);
      program_rx_i = 1'b1;
      idle(40);
      checks++;
      if (prog_mode_o !== 1'b0 || prog_err_o !== 1'b0 || n_we !== we0) begin
         errors++; $display("FAIL glitch_quiet got mode%b err%b we%0d exp 0 0 0", prog_mode_o, prog_err_o, n_we - we0);
      end
      send_byte(8'h49, 1'b1);
      send_byte(8'h5A, 1'b1);
      send_byte(8'h4C, 1'b1);
      checks++;
      if (prog_mode_o !== 1'b1) begin errors++; $display("FAIL glitch_preamble got %b exp 1", prog_mode_o); end
      send_word(32'd0);
      checks++;
      if (n_done - d0 !== 1) begin errors++; $display("FAIL glitch_done got %0d exp 1", n_done - d0); end
   endtask

   task automatic test_reset_mid();
      int we0, d0;
      send_pre();
      send_word(32'd2);
      send_byte(8'h11, 1'b1);
      send_byte(8'h22, 1'b1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      checks++;
      if ({prog_mode_o, prog_we_o, prog_done_o, prog_err_o, prog_addr_o, prog_data_o} !== 68'h0) begin
         errors++;
         $display("FAIL midreset_outputs got mode%b we%b done%b err%b addr%h data%h exp all 0",
                  prog_mode_o, prog_we_o, prog_done_o, prog_err_o, prog_addr_o, prog_data_o);
      end
      idle(2);
      rst_i = 1'b0;
      idle(4);
      we0 = n_we;
      d0  = n_done;
      send_byte(8'h33, 1'b1);
      send_byte(8'h44, 1'b1);
      checks++;
      if (n_we !== we0 || prog_mode_o !== 1'b0) begin
         errors++; $display("FAIL midreset_no_write got we%0d mode%b exp 0 0", n_we - we0, prog_mode_o);
      end
      send_pre();
      send_word(32'd1);
      send_word(32'h1234_5678);
      checks++;
      if (n_we - we0 !== 1 || wa[we0[3:0]] !== 32'h4000_0000 || wd[we0[3:0]] !== 32'h1234_5678) begin
         errors++; $display("FAIL midreset_transfer got %0d %h/%h exp 1 40000000/12345678",
                            n_we - we0, wa[we0[3:0]], wd[we0[3:0]]);
      end
      checks++;
      if (n_done - d0 !== 1 || prog_mode_o !== 1'b0) begin
         errors++; $display("FAIL midreset_done got done%0d mode%b exp 1 0", n_done - d0, prog_mode_o);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_resync();
      test_frame_err();
      test_glitch();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
